// File: rtl/timer_multi_pkg.sv
// Shared register map, CTRL bit positions and encodings for the multi-channel timer.
package timer_multi_pkg;

    localparam logic [3:0] REG_CTRL  = 4'h0;
    localparam logic [3:0] REG_COUNT = 4'h4;
    localparam logic [3:0] REG_VALUE = 4'h8;
    localparam logic [3:0] REG_PRESC = 4'hC;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_PEND = 2;
    localparam int CTRL_MODE = 3;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    localparam logic INT_ASSERT   = 1'b1;
    localparam logic INT_DEASSERT = 1'b0;

endpackage

// File: rtl/timer_multi_if.sv
// Simple peripheral slave bus: single-cycle write strobe, combinational read data.
interface timer_multi_if;

    logic [31:0] data_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] data_o;

    modport master (output data_i, output addr_i, output we_i, input data_o);
    modport slave  (input data_i, input addr_i, input we_i, output data_o);

endinterface

// File: rtl/timer_chan.sv
// One timer channel: CTRL/COUNT/VALUE/PRESC registers, prescaler, up-counter and expiry.
module timer_chan
    import timer_multi_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_sel,
    input  logic [3:0]  offset,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic               en_r;
    logic               ie_r;
    logic               pend_r;
    mode_e              mode_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   value_r;
    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_cnt_r;

    logic ctrl_wr_s;
    logic value_wr_s;
    logic presc_wr_s;
    logic tick_s;
    logic expire_s;
    logic unused_s;

    assign ctrl_wr_s  = wr_sel && (offset == REG_CTRL);
    assign value_wr_s = wr_sel && (offset == REG_VALUE);
    assign presc_wr_s = wr_sel && (offset == REG_PRESC);
    assign tick_s     = en_r && (presc_cnt_r == presc_r);
    // >= rather than == so a VALUE lowered below COUNT expires on the next tick
    assign expire_s   = tick_s && (count_r >= value_r);
    assign irq        = pend_r & ie_r;
    assign unused_s   = ^wdata;

    // Prescaler and counter; both held at zero while the channel is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_r <= {PRESC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else if (!en_r) begin
            presc_cnt_r <= {PRESC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            presc_cnt_r <= {PRESC_W{1'b0}};
            count_r     <= expire_s ? {CNT_W{1'b0}} : count_r + CNT_W'(1'b1);
        end else begin
            presc_cnt_r <= presc_cnt_r + PRESC_W'(1'b1);
        end
    end

    // Config registers; an expiry always lands in pending, even against a same-cycle W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r    <= 1'b0;
            ie_r    <= 1'b0;
            pend_r  <= 1'b0;
            mode_r  <= MODE_ONESHOT;
            value_r <= {CNT_W{1'b0}};
            presc_r <= {PRESC_W{1'b0}};
        end else begin
            pend_r <= expire_s | (pend_r & ~(ctrl_wr_s & wdata[CTRL_PEND]));
            if (ctrl_wr_s) begin
                en_r   <= wdata[CTRL_EN];
                ie_r   <= wdata[CTRL_IE];
                mode_r <= mode_e'(wdata[CTRL_MODE]);
            end else if (expire_s && (mode_r == MODE_ONESHOT)) begin
                en_r <= 1'b0;
            end
            if (value_wr_s) begin
                value_r <= wdata[CNT_W-1:0];
            end
            if (presc_wr_s) begin
                presc_r <= wdata[PRESC_W-1:0];
            end
        end
    end

    // Register read mux for this channel
    always_comb begin
        rdata = 32'd0;
        case (offset)
            REG_CTRL: begin
                rdata[CTRL_EN]   = en_r;
                rdata[CTRL_IE]   = ie_r;
                rdata[CTRL_PEND] = pend_r;
                rdata[CTRL_MODE] = mode_r;
            end
            REG_COUNT: rdata = 32'(count_r);
            REG_VALUE: rdata = 32'(value_r);
            REG_PRESC: rdata = 32'(presc_r);
            default:   rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/timer_multi.sv
// Multi-channel peripheral timer: address decode, NUM_CH channels, read mux and interrupt combine.
module timer_multi
    import timer_multi_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    timer_multi_if.slave      bus,
    output logic              int_sig_o,
    output logic [NUM_CH-1:0] int_vec_o
);

    logic [3:0]        chan_idx_s;
    logic [3:0]        reg_off_s;
    logic [31:0]       rdata_s [NUM_CH];
    logic [NUM_CH-1:0] irq_s;
    logic [31:0]       rd_mux_s;
    logic              unused_s;

    assign chan_idx_s = bus.addr_i[7:4];
    assign reg_off_s  = bus.addr_i[3:0];
    assign unused_s   = ^bus.addr_i[31:8];

    // Channel indices at or above NUM_CH never match a channel, so they read 0 and drop writes
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        timer_chan #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_sel (bus.we_i && (chan_idx_s == 4'(g))),
            .offset (reg_off_s),
            .wdata  (bus.data_i),
            .rdata  (rdata_s[g]),
            .irq    (irq_s[g])
        );
    end

    // One-hot select of the addressed channel's read data
    always_comb begin
        rd_mux_s = 32'd0;
        for (int n = 0; n < NUM_CH; n++) begin
            rd_mux_s = rd_mux_s | ((chan_idx_s == 4'(n)) ? rdata_s[n] : 32'd0);
        end
    end

    assign bus.data_o = rst_n ? rd_mux_s : 32'd0;
    assign int_vec_o  = irq_s;
    assign int_sig_o  = (|irq_s) ? INT_ASSERT : INT_DEASSERT;

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_timer_multi;

    localparam int NUM_CH = 4;

    logic              clk;
    logic              rst_n;
    logic              int_sig;
    logic [NUM_CH-1:0] int_vec;

    timer_multi_if bus ();

    timer_multi #(.NUM_CH(NUM_CH), .CNT_W(32), .PRESC_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .int_sig_o (int_sig),
        .int_vec_o (int_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state per channel
    bit          m_en    [NUM_CH];
    bit          m_ie    [NUM_CH];
    bit          m_pend  [NUM_CH];
    bit          m_mode  [NUM_CH];
    logic [31:0] m_cnt   [NUM_CH];
    logic [31:0] m_val   [NUM_CH];
    logic [15:0] m_presc [NUM_CH];
    logic [15:0] m_since [NUM_CH];   // cycles elapsed since enable or since last tick

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_en[c] = 0; m_ie[c] = 0; m_pend[c] = 0; m_mode[c] = 0;
            m_cnt[c] = 32'd0; m_val[c] = 32'd0; m_presc[c] = 16'd0; m_since[c] = 16'd0;
        end
    endtask

    // Advance the model by one clock using the bus inputs currently driven
    task automatic model_step();
        bit          tick, expired, wr;
        logic [3:0]  off;
        logic [31:0] d;
        off = bus.addr_i[3:0];
        d   = bus.data_i;
        for (int c = 0; c < NUM_CH; c++) begin
            tick    = m_en[c] && (m_since[c] == m_presc[c]);
            expired = tick && (m_cnt[c] >= m_val[c]);
            if (!m_en[c]) begin
                m_since[c] = 16'd0;
                m_cnt[c]   = 32'd0;
            end else if (tick) begin
                m_since[c] = 16'd0;
                m_cnt[c]   = expired ? 32'd0 : m_cnt[c] + 32'd1;
            end else begin
                m_since[c] = m_since[c] + 16'd1;
            end
            wr = bus.we_i && (int'(bus.addr_i[7:4]) == c);
            if (wr && off == 4'h0) begin
                m_en[c]   = d[0];
                m_ie[c]   = d[1];
                m_mode[c] = d[3];
                m_pend[c] = expired || (m_pend[c] && !d[2]);
            end else begin
                if (expired) m_pend[c] = 1;
                if (expired && !m_mode[c]) m_en[c] = 0;
            end
            if (wr && off == 4'h8) m_val[c]   = d;
            if (wr && off == 4'hC) m_presc[c] = d[15:0];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int c;
        c = int'(a[7:4]);
        if (c >= NUM_CH) return 32'd0;
        case (a[3:0])
            4'h0:    return {28'd0, m_mode[c], m_pend[c], m_ie[c], m_en[c]};
            4'h4:    return m_cnt[c];
            4'h8:    return m_val[c];
            4'hC:    return {16'd0, m_presc[c]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] model_vec();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_pend[c] & m_ie[c];
        return v;
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.we_i   = 1'b1;
        bus.addr_i = a;
        bus.data_i = d;
        step();
        bus.we_i   = 1'b0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        bus.addr_i = a;
        #1;
        d = bus.data_o;
    endtask

    task automatic check_read(input string tag, input logic [31:0] a);
        logic [31:0] d;
        read_reg(a, d);
        check(tag, d, model_read(a));
    endtask

    task automatic check_irq(input string tag);
        check({tag, "_vec"}, 32'(int_vec), 32'(model_vec()));
        check({tag, "_sig"}, 32'(int_sig), 32'(|model_vec()));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        int          ch;
        int          sel;

        rst_n      = 1'b0;
        bus.we_i   = 1'b0;
        bus.addr_i = 32'd0;
        bus.data_i = 32'd0;
        model_reset();
        #12;
        read_reg(32'h00, rd);
        check("rst_data", rd, 32'd0);
        check("rst_sig", 32'(int_sig), 32'd0);
        rst_n = 1'b1;
        check_read("rst_ctrl0", 32'h00);
        check_read("rst_val2", 32'h28);

        // One-shot on ch0: expiry six cycles after the enabling write
        bus_write(32'h0C, 32'd0);
        bus_write(32'h08, 32'd5);
        bus_write(32'h00, 32'h3);
        idle(5);
        read_reg(32'h00, rd);
        check("os_pend_early", rd, 32'h3);
        step();
        read_reg(32'h00, rd);
        check("os_ctrl", rd, 32'h6);
        check("os_vec", 32'(int_vec), 32'h1);
        check("os_sig", 32'(int_sig), 32'h1);
        read_reg(32'h04, rd);
        check("os_count", rd, 32'd0);
        bus_write(32'h00, 32'h4);
        check_irq("os_clr");

        // Periodic on ch2: expiry every 12 cycles, W1C in between, enable stays set
        bus_write(32'h2C, 32'd3);
        bus_write(32'h28, 32'd2);
        bus_write(32'h20, 32'hB);
        idle(11);
        read_reg(32'h20, rd);
        check("per_pre", rd, 32'hB);
        step();
        read_reg(32'h20, rd);
        check("per_hit", rd, 32'hF);
        bus_write(32'h20, 32'hF);
        read_reg(32'h20, rd);
        check("per_clr", rd, 32'hB);
        for (int i = 0; i < 11; i++) begin
            step();
            check_read("per_run", 32'h20);
        end
        read_reg(32'h20, rd);
        check("per_rehit", rd, 32'hF);

        // W1C race on ch1: clear written in the very cycle of expiry
        bus_write(32'h1C, 32'd0);
        bus_write(32'h18, 32'd3);
        bus_write(32'h10, 32'hB);
        idle(3);
        bus_write(32'h10, 32'hF);
        read_reg(32'h10, rd);
        check("race_ctrl", rd, 32'hF);
        check("race_vec1", 32'(int_vec[1]), 32'd1);
        check_irq("race");
        bus_write(32'h10, 32'h4);
        bus_write(32'h20, 32'h4);

        // Lower VALUE below a running COUNT on ch3, then ignored COUNT write
        bus_write(32'h3C, 32'd0);
        bus_write(32'h38, 32'd100);
        bus_write(32'h30, 32'h1);
        idle(50);
        read_reg(32'h34, rd);
        check("lv_count50", rd, 32'd50);
        bus_write(32'h38, 32'd10);
        check_read("lv_after_wr", 32'h34);
        step();
        read_reg(32'h34, rd);
        check("lv_count0", rd, 32'd0);
        read_reg(32'h30, rd);
        check("lv_ctrl", rd, 32'h4);
        bus_write(32'h30, 32'h9);
        idle(5);
        bus_write(32'h34, 32'h3);
        read_reg(32'h34, rd);
        check("cnt_wr_ignored", rd, 32'd6);
        bus_write(32'h30, 32'h4);

        // Independent channels 0 and 3, plus an out-of-range channel index
        bus_write(32'h08, 32'd2);
        bus_write(32'h00, 32'hB);
        bus_write(32'h38, 32'd4);
        bus_write(32'h30, 32'hB);
        for (int i = 0; i < 12; i++) begin
            step();
            check_irq("indep");
        end
        bus_write(32'h50, 32'hF);
        bus_write(32'h58, 32'd7);
        for (int o = 0; o < 4; o++) begin
            read_reg(32'h50 + 32'(o * 4), rd);
            check("ch5_read", rd, 32'd0);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            check_read("ch5_noalias_ctrl", 32'(c * 16));
            check_read("ch5_noalias_val", 32'(c * 16 + 8));
        end

        // Asynchronous reset mid-count with pending set
        check("pre_rst_sig", 32'(int_sig), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_sig", 32'(int_sig), 32'd0);
        check("async_vec", 32'(int_vec), 32'd0);
        read_reg(32'h00, rd);
        check("async_data", rd, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int o = 0; o < 4; o++) begin
                read_reg(32'(c * 16 + o * 4), rd);
                check("post_rst_reg", rd, 32'd0);
            end
        end
        idle(10);
        read_reg(32'h04, rd);
        check("post_rst_cnt", rd, 32'd0);
        check_irq("post_rst");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                ch  = $urandom_range(0, 5);
                sel = $urandom_range(0, 4);
                case (sel)
                    0:       begin a = 32'(ch * 16);     d = $urandom; end
                    1:       begin a = 32'(ch * 16 + 4); d = $urandom; end
                    2:       begin a = 32'(ch * 16 + 8); d = $urandom_range(0, 15); end
                    3:       begin a = 32'(ch * 16 + 12); d = $urandom_range(0, 3); end
                    default: begin a = 32'(ch * 16 + 6); d = $urandom; end
                endcase
                bus_write(a, d);
            end else begin
                step();
            end
            check_irq("rnd_irq");
            ch  = $urandom_range(0, 5);
            sel = $urandom_range(0, 4);
            check_read("rnd_rd", 32'(ch * 16 + ((sel == 4) ? 2 : sel * 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
